shared_mem_arbiter: RTL and testbench

- Arbitrates read/write access from NUM_REQ requesters to one shared single-port register array (DEPTH x DATA_WIDTH; default 11 x 8).
- Sequences each granted transaction onto the array port.
- Range-checks addresses and returns a per-requester response.
- Sits between requesting generate-instances and the storage array; one transaction in flight at a time.

---
 rtl/shared_mem_arbiter_if.sv | 40 ++++
 rtl/shared_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_arbiter_if.sv
// shared_mem_arbiter_if
//   Request/response handshake and array-port signals of the shared memory
//   arbiter, bundled so the arbiter and its environment share one port list.
//   Ports (signals):
//     req_valid/req_ready/req_we   per-requester handshake and direction
//     req_addr/req_wdata           packed per-requester payload
//     rsp_valid/rsp_rdata/rsp_err  per-requester response pulse and data
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  single-port array access
//   Modports: slave = arbiter side, master = requesters plus array side.
interface shared_mem_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
//   Round-robin arbiter giving NUM_REQ requesters serialized access to one
//   single-port register array. One transaction in flight at a time:
//   IDLE (grant) -> ACCESS (array strobe) -> WAIT (read data returns) ->
//   RESP (one-cycle response pulse). Out-of-range addresses skip the array
//   and go straight to RESP with rsp_err set.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   shared_mem_arbiter_if.slave (request, response, array port)
//     busy  high whenever the arbiter is not IDLE
module shared_mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 11,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_mem_arbiter_if.slave  bus,
    output logic                 busy
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0]  ONE       = NUM_REQ'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e                  state_q;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         id_q;
    logic                    we_q;
    logic                    busy_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    // Unpacked views of the packed request payloads.
    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first valid requester strictly after rr_ptr_q,
    // wrapping, so the last winner has lowest priority next time.
    logic                    found_d;
    logic [ID_W-1:0]         win_d;
    logic [ID_W-1:0]         sel;
    int                      idx;

    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        sel     = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            sel = ID_W'(idx);
            if (!found_d && bus.req_valid[sel]) begin
                found_d = 1'b1;
                win_d   = sel;
            end
        end
    end

    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic                    win_in_range;
    logic                    grant;

    assign win_we       = bus.req_we[win_d];
    assign win_addr     = addr_arr[win_d];
    assign win_wdata    = wdata_arr[win_d];
    // Compare one bit wider so DEPTH == 2**ADDR_WIDTH still fits.
    assign win_in_range = {1'b0, win_addr} < DEPTH_EXT;
    // Ready is combinational so the handshake completes in the grant cycle;
    // gated by rst so nothing is accepted while held in reset.
    assign grant        = !rst && (state_q == IDLE) && found_d;

    assign bus.req_ready = grant ? (ONE << win_d) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        rr_ptr_q <= win_d;
                        id_q     <= win_d;
                        we_q     <= win_we;
                        busy_q   <= 1'b1;
                        if (win_in_range) begin
                            state_q     <= ACCESS;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= win_we;
                            mem_addr_q  <= win_addr;
                            mem_wdata_q <= win_wdata;
                        end else begin
                            // Bad address: respond next cycle, array untouched.
                            state_q     <= RESP;
                            rsp_valid_q <= ONE << win_d;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    state_q     <= WAIT;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                WAIT: begin
                    // Array read data is valid in this cycle only.
                    state_q     <= RESP;
                    rsp_valid_q <= ONE << id_q;
                    rsp_rdata_q <= we_q ? '0 : bus.mem_rdata;
                    rsp_err_q   <= 1'b0;
                end
                RESP: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;
    localparam int NR = 2, DW = 8, DEPTH = 11, AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    shared_mem_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    shared_mem_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Storage array attached to the arbiter's port: registered read.
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    logic [DW-1:0] mem_rd_q = '0;
    assign bus.mem_rdata = mem_rd_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rd_q <= mem[bus.mem_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is described by its age in cycles since acceptance:
    // in range -> array access at age 1, response at age 3, idle at age 4;
    // out of range -> response at age 1, idle at age 2.
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
    int            m_ptr = NR - 1;
    bit            m_act = 0;
    int            m_age = 0;
    int            m_id  = 0;
    bit            m_we, m_err;
    int            m_addr;
    logic [DW-1:0] m_wdata, m_rd;

    logic [NR-1:0] e_ready, e_rv;
    logic [DW-1:0] e_rd, e_wdata;
    logic [AW-1:0] e_addr;
    logic          e_err, e_en, e_we, e_busy;
    bit            m_found;
    int            m_win;

    int cyc = 0;
    int g_id[$];
    int g_cyc[$];
    int rsp0_cnt  = 0;
    int memen_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : model
        e_ready = '0; e_rv = '0; e_rd = '0; e_err = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_busy = 1'b0;
        m_found = 0; m_win = 0;
        if (rst) begin
            m_act = 0;
            m_ptr = NR - 1;
        end else if (m_act) begin
            e_busy = 1'b1;
            if (m_err) begin
                if (m_age == 1) begin e_rv = NR'(1) << m_id; e_err = 1'b1; end
            end else begin
                if (m_age == 1) begin
                    e_en = 1'b1; e_we = m_we; e_addr = AW'(m_addr); e_wdata = m_wdata;
                end
                if (m_age == 3) begin
                    e_rv = NR'(1) << m_id;
                    e_rd = m_we ? '0 : m_rd;
                end
            end
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int ix;
                ix = (m_ptr + k) % NR;
                if (!m_found && bus.req_valid[ix]) begin m_found = 1; m_win = ix; end
            end
            if (m_found) e_ready = NR'(1) << m_win;
        end

        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rd));
        chk("rsp_err",   32'(bus.rsp_err),   32'(e_err));
        chk("mem_en",    32'(bus.mem_en),    32'(e_en));
        chk("mem_we",    32'(bus.mem_we),    32'(e_we));
        chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        chk("busy",      32'(busy),          32'(e_busy));

        for (int i = 0; i < NR; i++)
            if (bus.req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
        if (bus.rsp_valid[0]) rsp0_cnt++;
        if (bus.mem_en) memen_cnt++;

        // advance across the coming edge
        if (!rst) begin
            if (m_act) begin
                if (!m_err && m_age == 1) begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    else      m_rd = ref_mem[m_addr];
                end
                if ((m_err && m_age == 1) || m_age == 3) m_act = 0;
                else m_age++;
            end else if (m_found) begin
                m_act   = 1;
                m_age   = 1;
                m_id    = m_win;
                m_ptr   = m_win;
                m_we    = bus.req_we[m_win];
                m_addr  = int'(bus.req_addr[m_win*AW +: AW]);
                m_wdata = bus.req_wdata[m_win*DW +: DW];
                m_err   = (m_addr >= DEPTH);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drive(input int r, input bit we, input int addr, input int data);
        bus.req_valid[r]           = 1'b1;
        bus.req_we[r]              = we;
        bus.req_addr[r*AW +: AW]   = AW'(addr);
        bus.req_wdata[r*DW +: DW]  = DW'(data);
    endtask

    int c0, g0, m0;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        // reset state, with a request pending that must not be accepted
        drive(0, 1'b1, 3, 'h11);
        step();
        mid();
        chk("rst ready",  32'(bus.req_ready), 0);
        chk("rst busy",   32'(busy), 0);
        chk("rst mem_en", 32'(bus.mem_en), 0);
        chk("rst rsp",    32'(bus.rsp_valid), 0);
        idle_inputs();
        step(); step();
        @(posedge clk); #1 rst = 1'b0;

        // 1: write req0 addr 3 = A5
        drive(0, 1'b1, 3, 'hA5);
        mid(); chk("t1 ready", 32'(bus.req_ready), 32'h1);
        step(); idle_inputs();
        mid();
        chk("t1 mem_en",    32'(bus.mem_en), 1);
        chk("t1 mem_we",    32'(bus.mem_we), 1);
        chk("t1 mem_addr",  32'(bus.mem_addr), 3);
        chk("t1 mem_wdata", 32'(bus.mem_wdata), 32'hA5);
        step(); step(); mid();
        chk("t1 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1 rsp_err",   32'(bus.rsp_err), 0);
        chk("t1 rsp_rdata", 32'(bus.rsp_rdata), 0);
        step();

        // 2: read req1 addr 3 -> A5
        drive(1, 1'b0, 3, 0);
        mid(); chk("t2 ready", 32'(bus.req_ready), 32'h2);
        step(); idle_inputs();
        step(); step(); mid();
        chk("t2 rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("t2 rsp_rdata", 32'(bus.rsp_rdata), 32'hA5);
        step();

        // 4: out-of-range read at DEPTH
        m0 = memen_cnt;
        drive(0, 1'b0, 11, 0);
        mid(); chk("t4 ready", 32'(bus.req_ready), 32'h1);
        step(); idle_inputs();
        mid();
        chk("t4 rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t4 rsp_err",   32'(bus.rsp_err), 1);
        chk("t4 rsp_rdata", 32'(bus.rsp_rdata), 0);
        step(); mid();
        chk("t4 busy after", 32'(busy), 0);
        chk("t4 no mem_en",  32'(memen_cnt - m0), 0);
        step();

        // 3: both requesting from reset -> 0,1,0,1 every 4 cycles
        rst = 1'b1;
        drive(0, 1'b1, 5, 'h3C);
        drive(1, 1'b0, 5, 0);
        g_id.delete(); g_cyc.delete();
        step(); rst = 1'b0;
        repeat (17) step();
        idle_inputs();
        chk("t3 grants", 32'(g_id.size() >= 4), 1);
        if (g_id.size() >= 4) begin
            chk("t3 g0", 32'(g_id[0]), 0);
            chk("t3 g1", 32'(g_id[1]), 1);
            chk("t3 g2", 32'(g_id[2]), 0);
            chk("t3 g3", 32'(g_id[3]), 1);
            for (int i = 0; i < 3; i++) chk("t3 spacing", 32'(g_cyc[i+1] - g_cyc[i]), 4);
        end
        repeat (6) step();

        // 5a: reset during ACCESS of a write
        drive(0, 1'b1, 7, 'h77);
        mid(); chk("t5 ready", 32'(bus.req_ready), 32'h1);
        step(); idle_inputs();
        chk("t5 pre mem_en", 32'(bus.mem_en), 1);
        rst = 1'b1;
        #1;
        chk("t5 rst mem_en", 32'(bus.mem_en), 0);
        chk("t5 rst busy",   32'(busy), 0);
        drive(1, 1'b0, 7, 0);
        step(); rst = 1'b0;
        mid(); chk("t5 req1 first", 32'(bus.req_ready), 32'h2);
        step(); idle_inputs();
        step(); step(); mid();
        chk("t5 rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("t5 dropped wr", 32'(bus.rsp_rdata), 0);
        step();

        // 5b: reset during WAIT, then a tie goes to req0
        drive(0, 1'b0, 1, 0);
        mid(); chk("t5b ready", 32'(bus.req_ready), 32'h1);
        step(); idle_inputs();
        step();
        rst = 1'b1;
        drive(0, 1'b0, 1, 0);
        drive(1, 1'b0, 1, 0);
        step(); rst = 1'b0;
        mid(); chk("t5b tie", 32'(bus.req_ready), 32'h1);
        step(); idle_inputs();
        repeat (5) step();

        // 6: req0 pulses valid only during WAIT of a req1 transaction
        drive(1, 1'b0, 3, 0);
        mid(); chk("t6 ready", 32'(bus.req_ready), 32'h2);
        step(); idle_inputs();
        step();
        c0 = rsp0_cnt; g0 = g_id.size();
        drive(0, 1'b0, 2, 0);
        step(); idle_inputs();
        repeat (6) step();
        chk("t6 no grant", 32'(g_id.size() - g0), 0);
        chk("t6 no rsp",   32'(rsp0_cnt - c0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
